ram_tdp_be: RTL and testbench

Parametrised true dual-port block RAM with per-byte write enables, per-port enables and a selectable read-during-write mode. It has an optional output pipeline register, read-valid strobes and defined cross-port collision handling. It replaces the fixed write-first dual-port RAM wherever cache data arrays, TLB storage or shared buffers need byte-granular writes or a second output stage for timing. Memory is inferred as Xilinx BRAM (RAM_STYLE="BLOCK").

---
 rtl/ram_tdp_be.sv | 138 +++++++++++++
 tb/tb_ram_tdp_be.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_tdp_be.sv
// ram_tdp_be: true dual-port RAM with per-byte write enables and per-port enables.
// The read-during-write mode is selectable, and the output can have an extra
// pipeline stage. Each port has a read-valid strobe, and there is a cross-port
// collision flag.
// On a write/write collision at the same address, port A wins any shared lane.
// A port that only reads always sees the word stored before the edge.
module ram_tdp_be #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 12,
    parameter int BYTE_WIDTH = 8,
    parameter int READ_MODE  = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ena,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wea,
    input  logic [ADDR_WIDTH-1:0]            addra,
    input  logic [DATA_WIDTH-1:0]            dina,
    output logic [DATA_WIDTH-1:0]            douta,
    output logic                             valida,
    input  logic                             enb,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] web,
    input  logic [ADDR_WIDTH-1:0]            addrb,
    input  logic [DATA_WIDTH-1:0]            dinb,
    output logic [DATA_WIDTH-1:0]            doutb,
    output logic                             validb,
    output logic                             coll
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Both ports are packed into arrays so the read path is written only once.
    logic [1:0]            en;
    logic [NB-1:0]         we     [2];
    logic [ADDR_WIDTH-1:0] addr   [2];
    logic [DATA_WIDTH-1:0] din    [2];
    logic [DATA_WIDTH-1:0] stored [2];
    logic                  coll_reg;

    assign en      = {enb, ena};
    assign we[0]   = wea;
    assign we[1]   = web;
    assign addr[0] = addra;
    assign addr[1] = addrb;
    assign din[0]  = dina;
    assign din[1]  = dinb;

    // Both ports write in one process. Port B lanes are applied first, so port A
    // takes any lane that both ports write. No write happens while reset is high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                if (enb && web[i])
                    mem[addrb][i*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (ena && wea[i])
                    mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_WIDTH-1:0] merged;
            logic [DATA_WIDTH-1:0] word_next;
            logic                  prod_next;
            logic [DATA_WIDTH-1:0] dout_reg;
            logic                  valid_reg;

            assign stored[gi] = mem[addr[gi]];

            // Write-first data merges only this port's own write lanes.
            for (gj = 0; gj < NB; gj++) begin : g_lane
                assign merged[gj*BYTE_WIDTH +: BYTE_WIDTH] = we[gi][gj]
                    ? din[gi][gj*BYTE_WIDTH +: BYTE_WIDTH]
                    : stored[gi][gj*BYTE_WIDTH +: BYTE_WIDTH];
            end

            // Decide whether this access produces read data, and which word it is.
            always_comb begin
                prod_next = en[gi] && ((READ_MODE != 2) || (we[gi] == '0));
                word_next = (READ_MODE == 0) ? merged : stored[gi];
            end

            if (OUT_REG == 0) begin : g_direct
                // Single-stage output: dout holds its value when there is no producing access.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        dout_reg  <= '0;
                        valid_reg <= 1'b0;
                    end else begin
                        valid_reg <= prod_next;
                        if (prod_next)
                            dout_reg <= word_next;
                    end
                end
            end else begin : g_piped
                logic [DATA_WIDTH-1:0] s1_data_reg;
                logic                  s1_valid_reg;

                // Stage 1 runs every cycle. Stage 2 takes new data only when stage 1 holds a result.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        s1_data_reg  <= '0;
                        s1_valid_reg <= 1'b0;
                        dout_reg     <= '0;
                        valid_reg    <= 1'b0;
                    end else begin
                        s1_valid_reg <= prod_next;
                        if (prod_next)
                            s1_data_reg <= word_next;
                        valid_reg <= s1_valid_reg;
                        if (s1_valid_reg)
                            dout_reg <= s1_data_reg;
                    end
                end
            end
        end
    endgenerate

    // The collision flag pulses one edge after the access, whatever the output pipeline depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            coll_reg <= 1'b0;
        else
            coll_reg <= ena && enb && (addra == addrb) && ((|wea) || (|web));
    end

    assign douta  = g_port[0].dout_reg;
    assign valida = g_port[0].valid_reg;
    assign doutb  = g_port[1].dout_reg;
    assign validb = g_port[1].valid_reg;
    assign coll   = coll_reg;

endmodule

// File: tb/tb_ram_tdp_be.sv
// tb_ram_tdp_be: six instances cover every READ_MODE / OUT_REG combination.
// All six share one stimulus stream.
// Instance index c: READ_MODE = c % 3, OUT_REG = c / 3.
module tb_ram_tdp_be;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NB = 4;
    localparam int NC = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0, enb = 1'b0;
    logic [NB-1:0] wea = '0, web = '0;
    logic [AW-1:0] addra = '0, addrb = '0;
    logic [DW-1:0] dina = '0, dinb = '0;

    logic [DW-1:0] douta_w [NC];
    logic [DW-1:0] doutb_w [NC];
    logic          valida_w [NC];
    logic          validb_w [NC];
    logic          coll_w [NC];

    int chk = 0;
    int err = 0;

    // reference model state
    logic [DW-1:0] m_mem [32];
    logic [DW-1:0] m_da [NC], m_db [NC], m_s1da [NC], m_s1db [NC];
    logic          m_va [NC], m_vb [NC], m_s1va [NC], m_s1vb [NC];
    logic          m_coll;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NC; gi++) begin : g_dut
            ram_tdp_be #(
                .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8),
                .READ_MODE(gi % 3), .OUT_REG(gi / 3)
            ) u_dut (
                .clk(clk), .rst(rst),
                .ena(ena), .wea(wea), .addra(addra), .dina(dina),
                .douta(douta_w[gi]), .valida(valida_w[gi]),
                .enb(enb), .web(web), .addrb(addrb), .dinb(dinb),
                .doutb(doutb_w[gi]), .validb(validb_w[gi]),
                .coll(coll_w[gi])
            );
        end
    endgenerate

    task automatic port_word(input int m, input logic en, input logic [NB-1:0] we,
                             input logic [AW-1:0] a, input logic [DW-1:0] d,
                             output logic prod, output logic [DW-1:0] w);
        logic [DW-1:0] old, mrg;
        old = m_mem[a];
        mrg = old;
        for (int l = 0; l < NB; l++)
            if (we[l]) mrg[l*8 +: 8] = d[l*8 +: 8];
        prod = en && (m != 2 || we == '0);
        w = (m == 0) ? mrg : old;
    endtask

    task automatic model_step();
        logic pa, pb;
        logic [DW-1:0] wa, wb;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                m_da[c] = '0; m_db[c] = '0; m_s1da[c] = '0; m_s1db[c] = '0;
                m_va[c] = 1'b0; m_vb[c] = 1'b0; m_s1va[c] = 1'b0; m_s1vb[c] = 1'b0;
            end
            m_coll = 1'b0;
            return;
        end
        for (int c = 0; c < NC; c++) begin
            port_word(c % 3, ena, wea, addra, dina, pa, wa);
            port_word(c % 3, enb, web, addrb, dinb, pb, wb);
            if (c < 3) begin
                if (pa) m_da[c] = wa;
                m_va[c] = pa;
                if (pb) m_db[c] = wb;
                m_vb[c] = pb;
            end else begin
                if (m_s1va[c]) m_da[c] = m_s1da[c];
                m_va[c] = m_s1va[c];
                m_s1va[c] = pa;
                if (pa) m_s1da[c] = wa;
                if (m_s1vb[c]) m_db[c] = m_s1db[c];
                m_vb[c] = m_s1vb[c];
                m_s1vb[c] = pb;
                if (pb) m_s1db[c] = wb;
            end
        end
        m_coll = ena && enb && (addra == addrb) && ((|wea) || (|web));
        for (int l = 0; l < NB; l++)
            if (enb && web[l]) m_mem[addrb][l*8 +: 8] = dinb[l*8 +: 8];
        for (int l = 0; l < NB; l++)
            if (ena && wea[l]) m_mem[addra][l*8 +: 8] = dina[l*8 +: 8];
    endtask

    // One transaction: update the model with the current inputs, clock once, then sample #1 after the edge.
    task automatic step(input bit quiet = 1'b0);
        if (!quiet)
            $display("txn t=%0t rst=%0b A:en=%0b we=%h a=%0d d=%h B:en=%0b we=%h a=%0d d=%h",
                     $time, rst, ena, wea, addra, dina, enb, web, addrb, dinb);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ena = 1'b0; enb = 1'b0; wea = '0; web = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        step(); step();
        for (int c = 0; c < NC; c++) begin
            chk++; if (douta_w[c] !== '0) begin err++; $display("FAIL rst_douta[%0d]: got %h want 0", c, douta_w[c]); end
            chk++; if (doutb_w[c] !== '0) begin err++; $display("FAIL rst_doutb[%0d]: got %h want 0", c, doutb_w[c]); end
            chk++; if (valida_w[c] !== 1'b0) begin err++; $display("FAIL rst_valida[%0d]: got %b want 0", c, valida_w[c]); end
            chk++; if (validb_w[c] !== 1'b0) begin err++; $display("FAIL rst_validb[%0d]: got %b want 0", c, validb_w[c]); end
            chk++; if (coll_w[c] !== 1'b0) begin err++; $display("FAIL rst_coll[%0d]: got %b want 0", c, coll_w[c]); end
        end
        rst = 1'b0;
    endtask

    task automatic test_write_first();
        ena = 1'b1; wea = 4'hF; addra = 5'd16; dina = 32'hDEADBEEF;
        step();
        chk++; if (douta_w[0] !== 32'hDEADBEEF) begin err++; $display("FAIL wf_full: got %h want DEADBEEF", douta_w[0]); end
        chk++; if (valida_w[0] !== 1'b1) begin err++; $display("FAIL wf_valid: got %b want 1", valida_w[0]); end
        wea = 4'h3; dina = 32'h00001234;
        step();
        chk++; if (douta_w[0] !== 32'hDEAD1234) begin err++; $display("FAIL wf_merge: got %h want DEAD1234", douta_w[0]); end
        ena = 1'b0; wea = '0; enb = 1'b1; web = '0; addrb = 5'd16;
        step();
        chk++; if (doutb_w[0] !== 32'hDEAD1234) begin err++; $display("FAIL wf_readb: got %h want DEAD1234", doutb_w[0]); end
        chk++; if (validb_w[0] !== 1'b1) begin err++; $display("FAIL wf_validb: got %b want 1", validb_w[0]); end
        chk++; if (valida_w[0] !== 1'b0) begin err++; $display("FAIL wf_valida_off: got %b want 0", valida_w[0]); end
        chk++; if (douta_w[0] !== 32'hDEAD1234) begin err++; $display("FAIL wf_douta_hold: got %h want DEAD1234", douta_w[0]); end
        enb = 1'b0;
        step();
        chk++; if (validb_w[0] !== 1'b0) begin err++; $display("FAIL wf_validb_pulse: got %b want 0", validb_w[0]); end
        chk++; if (doutb_w[0] !== 32'hDEAD1234) begin err++; $display("FAIL wf_doutb_hold: got %h want DEAD1234", doutb_w[0]); end
    endtask

    task automatic test_read_modes();
        ena = 1'b1; wea = 4'hF; addra = 5'd5; dina = 32'h11111111;
        step();
        chk++; if (valida_w[2] !== 1'b0) begin err++; $display("FAIL nc_novalid1: got %b want 0", valida_w[2]); end
        dina = 32'h22222222;
        step();
        chk++; if (douta_w[1] !== 32'h11111111) begin err++; $display("FAIL rf_old: got %h want 11111111", douta_w[1]); end
        chk++; if (valida_w[1] !== 1'b1) begin err++; $display("FAIL rf_valid: got %b want 1", valida_w[1]); end
        chk++; if (douta_w[2] !== 32'h0) begin err++; $display("FAIL nc_hold: got %h want 00000000", douta_w[2]); end
        chk++; if (valida_w[2] !== 1'b0) begin err++; $display("FAIL nc_novalid2: got %b want 0", valida_w[2]); end
        wea = '0;
        step();
        chk++; if (douta_w[1] !== 32'h22222222) begin err++; $display("FAIL rf_read: got %h want 22222222", douta_w[1]); end
        chk++; if (douta_w[2] !== 32'h22222222) begin err++; $display("FAIL nc_read: got %h want 22222222", douta_w[2]); end
        chk++; if (valida_w[2] !== 1'b1) begin err++; $display("FAIL nc_read_valid: got %b want 1", valida_w[2]); end
        idle();
        step();
    endtask

    task automatic test_collision();
        ena = 1'b1; wea = 4'hF; addra = 5'd7; dina = 32'h0;
        step();
        chk++; if (coll_w[0] !== 1'b0) begin err++; $display("FAIL coll_none: got %b want 0", coll_w[0]); end
        wea = 4'h3; dina = 32'hAAAAAAAA;
        enb = 1'b1; web = 4'h6; addrb = 5'd7; dinb = 32'hBBBBBBBB;
        step();
        chk++; if (coll_w[0] !== 1'b1) begin err++; $display("FAIL coll_ww: got %b want 1", coll_w[0]); end
        chk++; if (douta_w[0] !== 32'h0000AAAA) begin err++; $display("FAIL coll_ww_douta: got %h want 0000AAAA", douta_w[0]); end
        chk++; if (doutb_w[0] !== 32'h00BBBB00) begin err++; $display("FAIL coll_ww_doutb: got %h want 00BBBB00", doutb_w[0]); end
        chk++; if (douta_w[1] !== 32'h0) begin err++; $display("FAIL coll_ww_rf: got %h want 00000000", douta_w[1]); end
        idle();
        step();
        chk++; if (coll_w[0] !== 1'b0) begin err++; $display("FAIL coll_pulse: got %b want 0", coll_w[0]); end
        enb = 1'b1; web = '0; addrb = 5'd7;
        step();
        chk++; if (doutb_w[0] !== 32'h00BBAAAA) begin err++; $display("FAIL coll_array: got %h want 00BBAAAA", doutb_w[0]); end
        ena = 1'b1; wea = 4'hF; addra = 5'd7; dina = 32'h12345678;
        step();
        chk++; if (doutb_w[0] !== 32'h00BBAAAA) begin err++; $display("FAIL coll_rw_old: got %h want 00BBAAAA", doutb_w[0]); end
        chk++; if (coll_w[0] !== 1'b1) begin err++; $display("FAIL coll_rw: got %b want 1", coll_w[0]); end
        chk++; if (coll_w[3] !== 1'b1) begin err++; $display("FAIL coll_rw_piped: got %b want 1", coll_w[3]); end
        chk++; if (douta_w[0] !== 32'h12345678) begin err++; $display("FAIL coll_rw_douta: got %h want 12345678", douta_w[0]); end
        ena = 1'b0; wea = '0;
        step();
        chk++; if (doutb_w[0] !== 32'h12345678) begin err++; $display("FAIL coll_rw_new: got %h want 12345678", doutb_w[0]); end
        chk++; if (coll_w[0] !== 1'b0) begin err++; $display("FAIL coll_rw_pulse: got %b want 0", coll_w[0]); end
        idle();
        step();
    endtask

    task automatic test_out_reg();
        ena = 1'b1; wea = 4'hF;
        addra = 5'd1; dina = 32'h101; step();
        addra = 5'd2; dina = 32'h202; step();
        addra = 5'd3; dina = 32'h303; step();
        idle(); step(); step();
        ena = 1'b1; addra = 5'd1;
        step();
        chk++; if (valida_w[3] !== 1'b0) begin err++; $display("FAIL or_lat: got %b want 0", valida_w[3]); end
        addra = 5'd2;
        step();
        chk++; if (douta_w[3] !== 32'h101 || valida_w[3] !== 1'b1) begin err++; $display("FAIL or_r1: got %h/%b want 00000101/1", douta_w[3], valida_w[3]); end
        addra = 5'd3;
        step();
        chk++; if (douta_w[3] !== 32'h202 || valida_w[3] !== 1'b1) begin err++; $display("FAIL or_r2: got %h/%b want 00000202/1", douta_w[3], valida_w[3]); end
        ena = 1'b0;
        step();
        chk++; if (douta_w[3] !== 32'h303 || valida_w[3] !== 1'b1) begin err++; $display("FAIL or_r3: got %h/%b want 00000303/1", douta_w[3], valida_w[3]); end
        ena = 1'b1; addra = 5'd1;
        step();
        chk++; if (douta_w[3] !== 32'h303 || valida_w[3] !== 1'b0) begin err++; $display("FAIL or_gap: got %h/%b want 00000303/0", douta_w[3], valida_w[3]); end
        ena = 1'b0;
        step();
        chk++; if (douta_w[3] !== 32'h101 || valida_w[3] !== 1'b1) begin err++; $display("FAIL or_r4: got %h/%b want 00000101/1", douta_w[3], valida_w[3]); end
        step();
        chk++; if (valida_w[3] !== 1'b0) begin err++; $display("FAIL or_end: got %b want 0", valida_w[3]); end
    endtask

    task automatic test_reset_mid();
        ena = 1'b1; wea = 4'hF; addra = 5'd9; dina = 32'h99999999;
        enb = 1'b1; web = '0; addrb = 5'd9;
        step();
        chk++; if (coll_w[0] !== 1'b1) begin err++; $display("FAIL rm_precoll: got %b want 1", coll_w[0]); end
        chk++; if (douta_w[0] !== 32'h99999999) begin err++; $display("FAIL rm_prewrite: got %h want 99999999", douta_w[0]); end
        rst = 1'b1;
        #1;
        for (int c = 0; c < NC; c++) begin
            chk++; if (douta_w[c] !== '0 || doutb_w[c] !== '0) begin err++; $display("FAIL rm_dout[%0d]: got %h/%h want 0/0", c, douta_w[c], doutb_w[c]); end
            chk++; if (valida_w[c] !== 1'b0 || validb_w[c] !== 1'b0) begin err++; $display("FAIL rm_valid[%0d]: got %b/%b want 0/0", c, valida_w[c], validb_w[c]); end
            chk++; if (coll_w[c] !== 1'b0) begin err++; $display("FAIL rm_coll[%0d]: got %b want 0", c, coll_w[c]); end
        end
        enb = 1'b0; dina = 32'hFFFFFFFF;
        step();
        chk++; if (douta_w[0] !== '0) begin err++; $display("FAIL rm_held: got %h want 0", douta_w[0]); end
        rst = 1'b0;
        wea = '0; addra = 5'd9; enb = 1'b1; addrb = 5'd16;
        step();
        chk++; if (douta_w[0] !== 32'h99999999) begin err++; $display("FAIL rm_wr_suppressed: got %h want 99999999", douta_w[0]); end
        chk++; if (doutb_w[0] !== 32'hDEAD1234) begin err++; $display("FAIL rm_keep: got %h want DEAD1234", doutb_w[0]); end
        chk++; if (valida_w[3] !== 1'b0 || validb_w[3] !== 1'b0) begin err++; $display("FAIL rm_flush: got %b/%b want 0/0", valida_w[3], validb_w[3]); end
        idle();
        step();
        chk++; if (douta_w[3] !== 32'h99999999 || valida_w[3] !== 1'b1) begin err++; $display("FAIL rm_piped_a: got %h/%b want 99999999/1", douta_w[3], valida_w[3]); end
        chk++; if (doutb_w[3] !== 32'hDEAD1234 || validb_w[3] !== 1'b1) begin err++; $display("FAIL rm_piped_b: got %h/%b want DEAD1234/1", doutb_w[3], validb_w[3]); end
        step();
    endtask

    task automatic test_random();
        int shown = 0;
        ena = 1'b1; wea = 4'hF; enb = 1'b0;
        for (int a = 0; a < 32; a++) begin
            addra = AW'(a); dina = $urandom;
            step();
        end
        idle(); step(); step();
        for (int n = 0; n < 10000; n++) begin
            ena = ($urandom_range(0, 3) != 0);
            enb = ($urandom_range(0, 3) != 0);
            wea = ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0;
            web = ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0;
            addra = AW'($urandom);
            addrb = ($urandom_range(0, 3) == 0) ? addra : AW'($urandom);
            dina = $urandom;
            dinb = $urandom;
            step();
            for (int c = 0; c < NC; c++) begin
                chk++;
                if (douta_w[c] !== m_da[c] || valida_w[c] !== m_va[c] ||
                    doutb_w[c] !== m_db[c] || validb_w[c] !== m_vb[c] || coll_w[c] !== m_coll) begin
                    err++;
                    if (shown < 20) begin
                        shown++;
                        $display("FAIL rand[%0d] cyc=%0d: got A=%h/%b B=%h/%b c=%b want A=%h/%b B=%h/%b c=%b",
                                 c, n, douta_w[c], valida_w[c], doutb_w[c], validb_w[c], coll_w[c],
                                 m_da[c], m_va[c], m_db[c], m_vb[c], m_coll);
                    end
                end
            end
        end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_write_first();
        test_read_modes();
        test_collision();
        test_out_reg();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end
endmodule
